// File: rtl/oh_rrmux.sv
// N:1 round-robin multiplexer with valid/ready channels, one registered output
// stage and optional packet locking so multi-beat packets are never interleaved.
module oh_rrmux #(
  parameter int N    = 3,
  parameter int DW   = 32,
  parameter int LOCK = 1,
  parameter int SW   = $clog2(N)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [N-1:0]      in_valid,
  input  logic [N*DW-1:0]   in_data,
  input  logic [N-1:0]      in_last,
  output logic [N-1:0]      in_ready,
  output logic              out_valid,
  output logic [DW-1:0]     out_data,
  output logic              out_last,
  output logic [SW-1:0]     out_sel,
  input  logic              out_ready
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] lk;
  logic          lock;

  logic [SW-1:0] winner;
  logic [SW-1:0] hi_idx;
  logic [SW-1:0] lo_idx;
  logic [SW-1:0] next_ptr;
  logic          has_winner;
  logic          hi_hit;
  logic          lo_hit;
  logic          load;
  logic          transfer;
  logic [DW-1:0] sel_data;
  logic          sel_last;
  logic          sel_valid;

  // Rotating priority: the lowest valid index at or above ptr wins, otherwise
  // the lowest valid index overall (the wrapped-around part of the scan).
  always_comb begin
    hi_hit     = 1'b0;
    lo_hit     = 1'b0;
    hi_idx     = '0;
    lo_idx     = '0;
    has_winner = 1'b0;
    winner     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        lo_hit = 1'b1;
        lo_idx = SW'(i);
      end
      if (in_valid[i] && (SW'(i) >= ptr)) begin
        hi_hit = 1'b1;
        hi_idx = SW'(i);
      end
    end
    if (lock) begin
      has_winner = 1'b1;
      winner     = lk;
    end else if (hi_hit) begin
      has_winner = 1'b1;
      winner     = hi_idx;
    end else if (lo_hit) begin
      has_winner = 1'b1;
      winner     = lo_idx;
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    in_ready  = '0;
    for (int i = 0; i < N; i++) begin
      if (winner == SW'(i)) begin
        sel_data  = in_data[i*DW +: DW];
        sel_last  = in_last[i];
        sel_valid = in_valid[i];
        in_ready[i] = load & has_winner;
      end
    end
  end

  // Gating with nreset keeps every in_ready low while the block is held in reset.
  assign load     = nreset & (~out_valid | out_ready);
  assign transfer = load & has_winner & sel_valid;
  assign next_ptr = (winner == SW'(N - 1)) ? '0 : winner + SW'(1);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
      ptr       <= '0;
      lock      <= 1'b0;
      lk        <= '0;
    end else begin
      if (load) begin
        out_valid <= transfer;
        if (transfer) begin
          out_data <= sel_data;
          out_last <= sel_last;
          out_sel  <= winner;
        end
      end
      if (transfer) begin
        if ((LOCK != 0) && !sel_last) begin
          lock <= 1'b1;
          lk   <= winner;
        end else begin
          lock <= 1'b0;
          ptr  <= next_ptr;
        end
      end
    end
  end

endmodule

// File: tb/tb_oh_rrmux.sv
// Scoreboard bench for oh_rrmux: a locking 3-channel instance and a
// non-locking 5-channel instance driven with hand-computed directed vectors.
module tb_oh_rrmux;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  logic [2:0]  valid3, last3, ready3;
  logic [23:0] data3;
  logic        ov3, ol3, ordy3;
  logic [7:0]  od3;
  logic [1:0]  os3;

  logic [4:0]  valid5, last5, ready5;
  logic [39:0] data5;
  logic        ov5, ol5, ordy5;
  logic [7:0]  od5;
  logic [2:0]  os5;

  oh_rrmux #(.N(3), .DW(8), .LOCK(1)) dut (
    .clk(clk), .nreset(nreset),
    .in_valid(valid3), .in_data(data3), .in_last(last3), .in_ready(ready3),
    .out_valid(ov3), .out_data(od3), .out_last(ol3), .out_sel(os3),
    .out_ready(ordy3)
  );

  oh_rrmux #(.N(5), .DW(8), .LOCK(0)) dut5 (
    .clk(clk), .nreset(nreset),
    .in_valid(valid5), .in_data(data5), .in_last(last5), .in_ready(ready5),
    .out_valid(ov5), .out_data(od5), .out_last(ol5), .out_sel(os5),
    .out_ready(ordy5)
  );

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t q3[$];
  beat_t q5[$];
  beat_t e3, e5;
  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] v, input logic [23:0] d, input logic [2:0] l,
                               input logic ordy, input logic [2:0] exp_rdy, input string name);
    @(negedge clk);
    valid3 = v;
    data3  = d;
    last3  = l;
    ordy3  = ordy;
    #1;
    checkOutput(name, {29'd0, ready3}, {29'd0, exp_rdy});
  endtask

  task automatic applyStimulus5(input logic [4:0] v, input logic [4:0] exp_rdy, input string name);
    @(negedge clk);
    valid5 = v;
    #1;
    checkOutput(name, {27'd0, ready5}, {27'd0, exp_rdy});
  endtask

  task automatic expect3(input logic [2:0] sel, input logic [7:0] data, input logic last);
    q3.push_back('{sel: sel, data: data, last: last});
  endtask

  task automatic expect5(input logic [2:0] sel, input logic [7:0] data, input logic last);
    q5.push_back('{sel: sel, data: data, last: last});
  endtask

  // A beat presented with out_ready high is consumed at the next rising edge.
  always @(negedge clk) begin
    #2;
    if (nreset === 1'b1 && ov3 === 1'b1 && ordy3 === 1'b1) begin
      if (q3.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL dut3 unexpected beat: got sel=%0d data=0x%0h last=%0b required none", os3, od3, ol3);
      end else begin
        e3 = q3.pop_front();
        checkOutput("dut3 beat {sel,data,last}", {20'd0, 1'b0, os3, od3, ol3}, {20'd0, e3});
      end
    end
    if (nreset === 1'b1 && ov5 === 1'b1 && ordy5 === 1'b1) begin
      if (q5.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL dut5 unexpected beat: got sel=%0d data=0x%0h last=%0b required none", os5, od5, ol5);
      end else begin
        e5 = q5.pop_front();
        checkOutput("dut5 beat {sel,data,last}", {20'd0, os5, od5, ol5}, {20'd0, e5});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  localparam logic [7:0] D0 = 8'hA0;
  localparam logic [7:0] D1 = 8'hB1;
  localparam logic [7:0] D2 = 8'hC2;

  initial begin
    nreset = 1'b0;
    valid3 = '0; data3 = '0; last3 = '0; ordy3 = 1'b1;
    valid5 = '0; data5 = {8'h44, 8'h43, 8'h42, 8'h41, 8'h40};
    last5  = 5'b01111; ordy5 = 1'b1;

    $display("[TB] reset with random inputs");
    repeat (3) begin
      @(negedge clk);
      valid3 = 3'($urandom);
      data3  = 24'($urandom);
      last3  = 3'($urandom);
      valid5 = 5'($urandom);
      #1;
      checkOutput("reset in_ready3", {29'd0, ready3}, 32'd0);
      checkOutput("reset out_valid3", {31'd0, ov3}, 32'd0);
      checkOutput("reset out_sel3", {30'd0, os3}, 32'd0);
      checkOutput("reset out_data3", {24'd0, od3}, 32'd0);
      checkOutput("reset in_ready5", {27'd0, ready5}, 32'd0);
    end
    @(negedge clk);
    valid3 = '0; valid5 = '0; last3 = '0;
    nreset = 1'b1;
    #1;
    checkOutput("release in_ready3", {29'd0, ready3}, 32'd0);
    checkOutput("release out_valid3", {31'd0, ov3}, 32'd0);

    $display("[TB] round-robin, all channels valid");
    for (int i = 0; i < 6; i++) begin
      case (i % 3)
        0: expect3(3'd0, D0, 1'b1);
        1: expect3(3'd1, D1, 1'b1);
        default: expect3(3'd2, D2, 1'b1);
      endcase
      applyStimulus(3'b111, {D2, D1, D0}, 3'b111, 1'b1, 3'b001 << (i % 3), "rr in_ready");
    end
    applyStimulus(3'b000, {D2, D1, D0}, 3'b111, 1'b1, 3'b000, "rr idle in_ready");

    $display("[TB] packet lock on channel 1");
    expect3(3'd0, D0, 1'b1);
    applyStimulus(3'b001, {D2, D1, D0}, 3'b111, 1'b1, 3'b001, "lock pre ch0");
    expect3(3'd1, 8'h11, 1'b0);
    applyStimulus(3'b111, {D2, 8'h11, D0}, 3'b101, 1'b1, 3'b010, "lock beat1");
    expect3(3'd1, 8'h12, 1'b0);
    applyStimulus(3'b111, {D2, 8'h12, D0}, 3'b101, 1'b1, 3'b010, "lock beat2");
    applyStimulus(3'b101, {D2, 8'h12, D0}, 3'b101, 1'b1, 3'b010, "lock gap holds grant");
    expect3(3'd1, 8'h13, 1'b1);
    applyStimulus(3'b111, {D2, 8'h13, D0}, 3'b111, 1'b1, 3'b010, "lock beat3");
    expect3(3'd2, D2, 1'b1);
    applyStimulus(3'b101, {D2, D1, D0}, 3'b111, 1'b1, 3'b100, "lock after ch2");
    expect3(3'd0, D0, 1'b1);
    applyStimulus(3'b101, {D2, D1, D0}, 3'b111, 1'b1, 3'b001, "lock after ch0");
    applyStimulus(3'b000, {D2, D1, D0}, 3'b111, 1'b1, 3'b000, "lock idle");

    $display("[TB] backpressure");
    expect3(3'd1, 8'h55, 1'b1);
    applyStimulus(3'b010, {D2, 8'h55, D0}, 3'b111, 1'b1, 3'b010, "bp load 0x55");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'b100, {D2, 8'h55, D0}, 3'b111, 1'b0, 3'b000, "bp stall in_ready");
      checkOutput("bp stall out_valid", {31'd0, ov3}, 32'd1);
      checkOutput("bp stall out_data", {24'd0, od3}, 32'h55);
      checkOutput("bp stall out_sel", {30'd0, os3}, 32'd1);
    end
    expect3(3'd2, D2, 1'b1);
    applyStimulus(3'b100, {D2, 8'h55, D0}, 3'b111, 1'b1, 3'b100, "bp release in_ready");
    applyStimulus(3'b000, {D2, 8'h55, D0}, 3'b111, 1'b1, 3'b000, "bp idle");
    applyStimulus(3'b000, {D2, 8'h55, D0}, 3'b111, 1'b1, 3'b000, "bp idle2");
    checkOutput("bp drained out_valid", {31'd0, ov3}, 32'd0);

    $display("[TB] reset mid-packet");
    applyStimulus(3'b100, {8'h21, D1, D0}, 3'b011, 1'b1, 3'b100, "mid-packet beat1");
    @(posedge clk);
    #1;
    checkOutput("mid-packet out_valid", {31'd0, ov3}, 32'd1);
    checkOutput("mid-packet out_data", {24'd0, od3}, 32'h21);
    checkOutput("mid-packet out_sel", {30'd0, os3}, 32'd2);
    #1;
    nreset = 1'b0;
    valid3 = '0;
    #1;
    checkOutput("mid-reset out_valid", {31'd0, ov3}, 32'd0);
    checkOutput("mid-reset out_data", {24'd0, od3}, 32'd0);
    checkOutput("mid-reset out_sel", {30'd0, os3}, 32'd0);
    checkOutput("mid-reset out_last", {31'd0, ol3}, 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    expect3(3'd0, D0, 1'b1);
    applyStimulus(3'b101, {8'h22, D1, D0}, 3'b011, 1'b1, 3'b001, "after reset ch0 wins");
    applyStimulus(3'b000, {8'h22, D1, D0}, 3'b011, 1'b1, 3'b000, "after reset idle");

    $display("[TB] wrap with five channels, no locking");
    expect5(3'd4, 8'h44, 1'b0);
    applyStimulus5(5'b10000, 5'b10000, "wrap ch4");
    expect5(3'd0, 8'h40, 1'b1);
    applyStimulus5(5'b10001, 5'b00001, "wrap ch0 after ch4");
    expect5(3'd4, 8'h44, 1'b0);
    applyStimulus5(5'b10001, 5'b10000, "wrap ch4 again");
    expect5(3'd1, 8'h41, 1'b1);
    applyStimulus5(5'b01010, 5'b00010, "wrap ch1");
    expect5(3'd3, 8'h43, 1'b1);
    applyStimulus5(5'b01010, 5'b01000, "wrap ch3");
    applyStimulus5(5'b00000, 5'b00000, "wrap idle");

    repeat (3) @(negedge clk);
    #3;
    checkOutput("dut3 scoreboard drained", q3.size(), 32'd0);
    checkOutput("dut5 scoreboard drained", q5.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oh_rrmux.md
Name: oh_rrmux

Overview:
- Parametrised N:1 data multiplexer with registered output: the next generation of the static 3-input select mux.
- Replaces static select lines with valid/ready channels and round-robin arbitration.
- Adds optional packet locking: a multi-beat packet is never interleaved with other channels.
- Sits in front of shared links and buses in OH fabrics; one output register stage, full throughput.

Parameters:
N, 3, number of input channels (N >= 2)
DW, 32, data width per channel
LOCK, 1, 1 = hold grant until beat with in_last accepted; 0 = re-arbitrate every beat
SW, $clog2(N), select width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
nreset  input  1  asynchronous active-low reset
in_valid  input  N  per-channel valid
in_data  input  N*DW  channel i at bits [i*DW +: DW]
in_last  input  N  per-channel last beat of packet
in_ready  output  N  per-channel ready, at most one bit set
out_valid  output  1  output beat valid
out_data  output  DW  selected data
out_last  output  1  last flag of selected beat
out_sel  output  SW  index of channel that sourced current out beat
out_ready  input  1  downstream ready

Behaviour:
- Reset (async assert, sync release is the integrator's job): out_valid=0, out_data=0, out_last=0, out_sel=0, rr pointer ptr=0, lock=0, locked channel lk=0.
- Output register loads when load = ~out_valid | out_ready (stall-free, one beat per cycle).
- Arbitration, combinational:
  - if lock=1: winner = lk, regardless of other requests;
  - else winner = first i with in_valid[i], scanning ptr, ptr+1, ... wrapping mod N.
  - No valid input and lock=0: no winner.
- in_ready[i] = (i == winner) & load. in_ready does not depend on in_valid of other channels beyond arbitration; in_ready stays 0 with no winner.
- Transfer on channel i: in_valid[i] & in_ready[i]. On a transfer:
  - out_data <= in_data[i], out_last <= in_last[i], out_sel <= i, out_valid <= 1.
- Load with no transfer: out_valid <= 0; out_data, out_last, out_sel hold their last values.
- Latency: input transfer to out_valid = 1 cycle. Hold with out_valid=1 & out_ready=0: all outputs stable.
- Pointer/lock update on transfer from channel i:
  - LOCK=1, in_last[i]=0: lock <= 1, lk <= i, ptr unchanged.
  - LOCK=1, in_last[i]=1: lock <= 0, ptr <= (i+1) mod N.
  - LOCK=0: ptr <= (i+1) mod N, lock stays 0, in_last is passed through only.
- Wrap: ptr = N-1 advances to 0; N not a power of two must wrap correctly (no out-of-range index).
- Locked channel deasserts in_valid mid-packet: grant stays on lk, other channels wait (no timeout).
- Simultaneous requests: exactly one in_ready asserted; fairness means each continuously-requesting channel is served within N packets.
- Reset mid-packet: lock cleared, output beat dropped, ptr=0.
- No combinational path from in_* to out_*; out_ready -> in_ready is combinational.

Test Plan:
- Reset: hold nreset=0 with random inputs -> out_valid=0, out_sel=0, in_ready=0; release with no valids -> in_ready stays 000.
- Round-robin, N=3, DW=8, LOCK=0, out_ready=1: all channels valid, last=1, data 0xA0/0xB1/0xC2 -> out_data 0xA0,0xB1,0xC2,0xA0,... with out_sel 0,1,2,0, one per cycle, 1-cycle latency.
- Packet lock, LOCK=1: ch1 sends 3 beats (last on 3rd), ch0 and ch2 valid throughout -> out_sel 1,1,1 then 2, then 0; ch0/ch2 in_ready=0 during the packet.
- Backpressure: out_ready=0 for 4 cycles with out_valid=1, out_data=0x55 -> outputs stable, in_ready=000; out_ready=1 -> next beat loaded the same cycle it is released, no beat lost or duplicated.
- Wrap, N=5: only ch4 then ch0 valid -> ptr advances to 0 after ch4, ch0 served next; sel never exceeds 4.
- Reset mid-packet: ch2 beat 1 of 3 accepted, assert nreset -> outputs cleared immediately; after release ch0 wins with ptr=0 and lock=0.
